// File: rtl/hamming_pkg.sv
// Shared definitions for the 22-bit SECDED codeword format.
// Holds the format constants, the parity-bit positions and the two helper
// functions (data placement, per-parity coverage mask). Any encoder or
// checker of this format imports this package so the layouts cannot drift.
package hamming_pkg;

  localparam int DATA_W = 16;
  localparam int CW_W   = 22;
  localparam int NPAR   = 5;

  // Codeword bit k carries Hamming position k+1, so parity p_j sits at 2^j-1.
  localparam logic [4:0] PAR_IDX [NPAR] = '{5'd0, 5'd1, 5'd3, 5'd7, 5'd15};
  localparam logic [4:0] OVR_IDX        = 5'd21;
  localparam logic [CW_W-1:0] PAR_POS_MASK = 22'h00808B;

  // Drop the data bits into every non-power-of-two position below the overall bit.
  function automatic logic [CW_W-1:0] place_data(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    cw        = '0;
    cw[2]     = d[0];
    cw[6:4]   = d[3:1];
    cw[14:8]  = d[10:4];
    cw[20:16] = d[15:11];
    return cw;
  endfunction

  // Data positions covered by parity p_j: position has bit j set, is not a
  // parity slot itself, and lies below the overall-parity bit.
  function automatic logic [CW_W-1:0] parity_mask(input int j);
    logic [CW_W-1:0] m;
    m = '0;
    for (int k = 0; k < CW_W - 1; k++) begin
      m[k] = ((((k + 1) >> j) & 1) != 0) && !PAR_POS_MASK[k];
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_enc_if.sv
// Stream bundle for hamming_enc: input word/flip-mask handshake and output
// codeword handshake.
//   slave  : the encoder's view (consumes input stream, produces codewords)
//   master : the environment's view (drives input stream, consumes codewords)
interface hamming_enc_if;
  import hamming_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic [CW_W-1:0]   in_flip;
  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   out_codeword;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_data, in_flip, in_valid, out_ready,
    output in_ready, out_codeword, out_valid
  );

  modport master (
    output in_data, in_flip, in_valid, out_ready,
    input  in_ready, out_codeword, out_valid
  );
endinterface

// File: rtl/hamming_pipe_stage.sv
// One valid/ready register slice of width W.
//   in_valid/in_ready/in_data    : upstream side
//   out_valid/out_ready/out_data : downstream side
// The slice loads whenever it is empty or its contents leave this cycle, so a
// full pipeline of these slices runs at one word per cycle. CLR_DATA selects
// whether the data register is also cleared by reset (only needed where the
// data is directly visible at a block output).
module hamming_pipe_stage #(
  parameter int W        = 8,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic load;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
    end
  end

  generate
    if (CLR_DATA) begin : g_clr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_data <= '0;
        end else if (load) begin
          out_data <= in_data;
        end
      end
    end else begin : g_noclr
      always_ff @(posedge clk) begin
        if (load) begin
          out_data <= in_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/hamming_enc.sv
// Streaming SECDED encoder: 16-bit data in, 22-bit codeword out.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : hamming_enc_if.slave (input word + flip mask, output codeword)
//   word_count : codewords delivered, modulo 2^CNT_W
// S1 registers the placed data with the five Hamming parities and the flip
// mask; S2 adds the overall parity, applies the mask and drives the output.
module hamming_enc
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  hamming_enc_if.slave     bus,
  output logic [CNT_W-1:0] word_count
);

  localparam int BODY_W = CW_W - 1;

  logic [CW_W-1:0]   placed_p0;
  logic [BODY_W-1:0] body_p0;

  logic                   vld_p1;
  logic                   rdy_p1;
  logic [CW_W+BODY_W-1:0] data_p1;
  logic [CW_W-1:0]        flip_p1;
  logic [BODY_W-1:0]      body_p1;
  logic [CW_W-1:0]        cw_p1;

  // ---- stage 0: place data and fill in the position-indexed parities ----
  always_comb begin
    placed_p0 = place_data(bus.in_data);
    body_p0   = placed_p0[BODY_W-1:0];
    for (int j = 0; j < NPAR; j++) begin
      body_p0[PAR_IDX[j]] = ^(placed_p0 & parity_mask(j));
    end
  end

  hamming_pipe_stage #(.W(CW_W + BODY_W), .CLR_DATA(1'b0)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({bus.in_flip, body_p0}),
    .out_valid (vld_p1),
    .out_ready (rdy_p1),
    .out_data  (data_p1)
  );

  // ---- stage 1: overall parity first, then the error-injection mask ----
  assign {flip_p1, body_p1} = data_p1;
  assign cw_p1 = {^body_p1, body_p1} ^ flip_p1;

  hamming_pipe_stage #(.W(CW_W), .CLR_DATA(1'b1)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_p1),
    .in_ready  (rdy_p1),
    .in_data   (cw_p1),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_codeword)
  );

  // ---- stage 2: delivered-word counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: doc/hamming_enc.md
# hamming_enc

Streaming SECDED encoder for the 22-bit Hamming codeword format used by the team's error-checking path. It accepts 16-bit data words over a valid/ready handshake and emits 22-bit codewords: five position-indexed Hamming parity bits plus one overall parity bit. An optional per-word flip mask injects single- or double-bit errors after encoding, for exercising the downstream checker. The block is a two-stage pipeline with full backpressure and a count of delivered codewords.

## Interface
- `CNT_W`, default 16: width of the delivered-word counter.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  16  data word to encode.
- `in_flip`  in  22  XOR mask applied to the finished codeword; sampled with `in_data`.
- `in_valid`  in  1  `in_data`/`in_flip` are valid.
- `in_ready`  out  1  encoder can accept this cycle.
- `out_codeword`  out  22  encoded word, with the flip mask applied.
- `out_valid`  out  1  `out_codeword` is valid.
- `out_ready`  in  1  consumer accepts this cycle.
- `word_count`  out  `CNT_W`  number of codewords delivered, modulo 2^CNT_W.

## Operation
- Codeword bit k holds position k+1. Parity bits sit at cw[0], cw[1], cw[3], cw[7] and cw[15]. Overall parity sits at cw[21].
- Data placement:
  - d[0] goes to cw[2].
  - d[1], d[2] and d[3] go to cw[4], cw[5] and cw[6].
  - d[4] through d[10] go to cw[8] through cw[14].
  - d[11] through d[15] go to cw[16] through cw[20].
- Parity bit p_j is stored at cw[2^j − 1], for j = 0 to 4. It equals the XOR of every data bit in cw[20:0] whose position has bit j set.
- cw[21] equals the XOR of cw[20:0], so the XOR of all 22 bits is 0.
- `out_codeword` = cw XOR flip mask. The mask is applied after the overall parity is computed.
- Pipeline stage S1 registers the placed data, the five parities and the mask, plus `s1_valid`.
- Pipeline stage S2 registers the final codeword and `out_valid`.
- Transfers:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
  - S2 loads when it is empty or when an output transfer happens in the same cycle.
  - S1 loads under the same rule with respect to S2 advancing.
- `in_ready` = !`s1_valid` || S1 advances this cycle. This is combinational from `out_ready`.
- `word_count` increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.
- Output stability: while `out_valid` is high and `out_ready` is low, `out_codeword` holds unchanged.
- Stalls: S1 holds its contents and `in_ready` is low only when both stages are full and `out_ready` is low.
- Simultaneous transfer: an input and an output transfer in the same cycle with both stages full keeps the pipeline full, with no bubble and no loss.

## Timing
- Latency: a word accepted in cycle N appears with `out_valid` high in cycle N+2 when there is no backpressure.
- Throughput: one word per cycle sustained.
- Values asserted by reset:
  - `s1_valid` = 0.
  - `out_valid` = 0.
  - `out_codeword` = 22'h000000.
  - `word_count` = 0.
  - `in_ready` = 1 once reset is released.
- Reset mid-operation: all in-flight words are discarded and never emitted, and the count clears immediately. It does not wait for a clock edge.
- The data path has no reset dependency beyond the cleared output register. The contents of an empty stage are don't-care.

## Structure
- Shared package `hamming_pkg`:
  - constants `DATA_W` = 16, `CW_W` = 22, `NPAR` = 5;
  - parity bit index list {0, 1, 3, 7, 15} and overall index 21;
  - a function that places the data bits into codeword positions;
  - a function that computes the parity mask for each j.

  The checker must reuse this package so that encoder and checker cannot diverge.
- One sub-module, `hamming_pipe_stage`: a parameter-width valid/ready register slice with asynchronous reset, instantiated for S1 and for S2.
- Parity computation and the counter live in `hamming_enc`.

## Test plan
- Reset: assert `rst` mid-stream with two words in flight → immediately `out_valid`=0, `word_count`=0, `out_codeword`=22'h000000; no in-flight word is ever emitted after release.
- Encoding values, zero flip mask, `out_ready`=1:
  - 16'h0000 → 22'h000000;
  - 16'hFFFF → 22'h1FFFFE;
  - 16'h0001 → 22'h200007.

  Each appears exactly 2 cycles after acceptance.
- Injection: 16'h0001 with `in_flip`=22'h000004 → 22'h200003. With `in_flip`=22'h200000 → 22'h000007.
- Backpressure: stream 16'h0000, 16'hFFFF, 16'h0001 back-to-back with `out_ready` low for 4 cycles after the first `out_valid`.
  - `in_ready` drops after the 2nd acceptance.
  - `out_codeword` stays stable while stalled.
  - All three words emerge in order with no loss or duplication.
- Full throughput: 100 random words with `out_ready`=1 and `in_valid`=1 → one output per cycle; each output decodes to zero syndrome and even overall parity under the package reference model.
- Wrap: `CNT_W`=4, deliver 17 words → `word_count` reads 1.
